// File: rtl/nco_sweep_ctrl_if.sv
// Sweep controller bundle: config/handshake in,
// NCO drive and status out.
interface nco_sweep_ctrl_if #(
    parameter int APR = 32,
    parameter int CW  = 16
);
    logic           start;
    logic           stop;
    logic [APR-1:0] f_start;
    logic [APR-1:0] f_step;
    logic [CW-1:0]  n_steps;
    logic [CW-1:0]  dwell;
    logic           nco_out_valid;
    logic [APR-1:0] phi_inc_o;
    logic           nco_clken;
    logic           busy;
    logic           done;
    logic [CW-1:0]  step_idx;

    modport master (
        output start, stop, f_start, f_step,
        output n_steps, dwell, nco_out_valid,
        input  phi_inc_o, nco_clken, busy,
        input  done, step_idx
    );

    modport slave (
        input  start, stop, f_start, f_step,
        input  n_steps, dwell, nco_out_valid,
        output phi_inc_o, nco_clken, busy,
        output done, step_idx
    );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep controller driving an NCO
// phase increment, dwelling a fixed number of valid samples per step.
module nco_sweep_ctrl #(
    parameter int APR = 32,
    parameter int CW  = 16
) (
    input logic             clk,
    input logic             reset_n,
    nco_sweep_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE, PRIME, DWELL, DONE
    } state_t;

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t         state_q, state_d;
    logic [APR-1:0] phi_q, phi_d;
    logic [APR-1:0] fstep_q, fstep_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  nlast_q, nlast_d;
    logic [CW-1:0]  dlast_q, dlast_d;
    logic           clken_q, clken_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            phi_q   <= '0;
            fstep_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            nlast_q <= '0;
            dlast_q <= '0;
            clken_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phi_q   <= phi_d;
            fstep_q <= fstep_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            nlast_q <= nlast_d;
            dlast_q <= dlast_d;
            clken_q <= clken_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Counts are latched as last-index values so 0 collapses to 1.
    always_comb begin
        state_d = state_q;
        phi_d   = phi_q;
        fstep_d = fstep_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        nlast_d = nlast_q;
        dlast_d = dlast_q;
        clken_d = clken_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    fstep_d = bus.f_step;
                    nlast_d = (bus.n_steps == '0) ? '0
                            : bus.n_steps - ONE;
                    dlast_d = (bus.dwell == '0) ? '0
                            : bus.dwell - ONE;
                    phi_d   = bus.f_start;
                    idx_d   = '0;
                    cnt_d   = '0;
                    clken_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = PRIME;
                end
            end
            PRIME: begin
                if (bus.stop) begin
                    clken_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (bus.nco_out_valid) begin
                    cnt_d   = '0;
                    state_d = DWELL;
                end
            end
            DWELL: begin
                if (bus.stop) begin
                    clken_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (bus.nco_out_valid) begin
                    if (cnt_q != dlast_q) begin
                        cnt_d = cnt_q + ONE;
                    end else if (idx_q < nlast_q) begin
                        phi_d = phi_q + fstep_q;
                        idx_d = idx_q + ONE;
                        cnt_d = '0;
                    end else begin
                        clken_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                clken_d = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.phi_inc_o = phi_q;
    assign bus.nco_clken = clken_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.step_idx  = idx_q;
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: sweep, gaps,
// wrap, abort, degenerate config, conflicts and reset.
module tb_nco_sweep_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    nco_sweep_ctrl_if #(.APR(32), .CW(16)) bus ();

    nco_sweep_ctrl #(.APR(32), .CW(16)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    // Invariants: done never with busy, never two cycles running.
    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if (bus.busy && bus.done) begin
                failures++;
                $display("FAIL busy_done_overlap got 1 exp 0");
            end
            checks++;
            if (bus.done && prev_done) begin
                failures++;
                $display("FAIL done_twice got 1 exp 0");
            end
            prev_done = bus.done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.stop = 0;
        bus.f_start = 32'h1234; bus.f_step = 32'h1;
        bus.n_steps = 16'd2; bus.dwell = 16'd2;
        bus.nco_out_valid = 1;
        reset_n = 0;
        tick(); tick();
        checks++;
        if ({bus.phi_inc_o, bus.step_idx, bus.nco_clken,
             bus.busy, bus.done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got phi=%h idx=%0d ck=%b b=%b d=%b exp all 0",
                     bus.phi_inc_o, bus.step_idx, bus.nco_clken,
                     bus.busy, bus.done);
        end
        reset_n = 1;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_autostart got %b exp 0", bus.busy);
        end
    endtask

    task automatic test_basic_sweep();
        logic [31:0] exp_phi;
        bus.f_start = 32'h1000; bus.f_step = 32'h100;
        bus.n_steps = 16'd3; bus.dwell = 16'd4;
        bus.nco_out_valid = 0;
        bus.start = 1;
        tick();
        bus.start = 0;
        bus.f_start = 32'h7777; bus.f_step = 32'hdead;
        bus.n_steps = 16'd1; bus.dwell = 16'd9;
        checks++;
        if (bus.phi_inc_o !== 32'h1000 || bus.busy !== 1'b1 ||
            bus.nco_clken !== 1'b1 || bus.step_idx !== 16'd0) begin
            failures++;
            $display("FAIL basic_start got phi=%h b=%b ck=%b idx=%0d exp 1000 1 1 0",
                     bus.phi_inc_o, bus.busy, bus.nco_clken, bus.step_idx);
        end
        repeat (10) tick();
        checks++;
        if (bus.phi_inc_o !== 32'h1000 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_prime_hold got phi=%h b=%b exp 1000 1",
                     bus.phi_inc_o, bus.busy);
        end
        bus.nco_out_valid = 1;
        tick();
        for (int s = 0; s < 3; s++) begin
            exp_phi = 32'h1000 + 32'h100 * s;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (bus.phi_inc_o !== exp_phi ||
                    bus.step_idx !== 16'(s) ||
                    bus.done !== 1'b0 || bus.busy !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_step s=%0d k=%0d got phi=%h idx=%0d d=%b exp phi=%h idx=%0d d=0",
                             s, k, bus.phi_inc_o, bus.step_idx,
                             bus.done, exp_phi, s);
                end
                bus.start = (s == 1 && k == 1);
                tick();
            end
        end
        bus.start = 0;
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 ||
            bus.nco_clken !== 1'b0 || bus.phi_inc_o !== 32'h1200 ||
            bus.step_idx !== 16'd2) begin
            failures++;
            $display("FAIL basic_done got d=%b b=%b ck=%b phi=%h idx=%0d exp 1 0 0 1200 2",
                     bus.done, bus.busy, bus.nco_clken,
                     bus.phi_inc_o, bus.step_idx);
        end
        bus.nco_out_valid = 0;
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.phi_inc_o !== 32'h1200) begin
            failures++;
            $display("FAIL basic_after_done got d=%b phi=%h exp 0 1200",
                     bus.done, bus.phi_inc_o);
        end
    endtask

    task automatic test_gapped_valid();
        logic [15:0] exp_idx;
        logic [31:0] exp_phi;
        bus.f_start = 32'h4000; bus.f_step = 32'h40;
        bus.n_steps = 16'd2; bus.dwell = 16'd3;
        bus.nco_out_valid = 0;
        bus.start = 1;
        tick();
        bus.start = 0;
        bus.nco_out_valid = 1;
        tick();
        for (int t = 1; t <= 12; t++) begin
            bus.nco_out_valid = (t % 2 == 0);
            tick();
            exp_idx = (t < 6) ? 16'd0 : 16'd1;
            exp_phi = (t < 6) ? 32'h4000 : 32'h4040;
            checks++;
            if (bus.step_idx !== exp_idx ||
                bus.phi_inc_o !== exp_phi ||
                bus.done !== (t == 12)) begin
                failures++;
                $display("FAIL gapped t=%0d got idx=%0d phi=%h d=%b exp idx=%0d phi=%h d=%b",
                         t, bus.step_idx, bus.phi_inc_o, bus.done,
                         exp_idx, exp_phi, (t == 12));
            end
        end
        bus.nco_out_valid = 0;
        tick();
    endtask

    task automatic test_wrap();
        bus.f_start = 32'hFFFFFF00; bus.f_step = 32'h200;
        bus.n_steps = 16'd2; bus.dwell = 16'd1;
        bus.nco_out_valid = 0;
        bus.start = 1;
        tick();
        bus.start = 0;
        bus.nco_out_valid = 1;
        tick();
        checks++;
        if (bus.phi_inc_o !== 32'hFFFFFF00) begin
            failures++;
            $display("FAIL wrap_first got %h exp ffffff00", bus.phi_inc_o);
        end
        tick();
        checks++;
        if (bus.phi_inc_o !== 32'h00000100 || bus.step_idx !== 16'd1) begin
            failures++;
            $display("FAIL wrap_second got phi=%h idx=%0d exp 00000100 1",
                     bus.phi_inc_o, bus.step_idx);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL wrap_done got %b exp 1", bus.done);
        end
        bus.nco_out_valid = 0;
        tick();
    endtask

    task automatic test_abort();
        bus.f_start = 32'h2000; bus.f_step = 32'h10;
        bus.n_steps = 16'd3; bus.dwell = 16'd2;
        bus.nco_out_valid = 1;
        bus.start = 1;
        tick();
        bus.start = 0;
        tick(); tick(); tick();
        checks++;
        if (bus.step_idx !== 16'd1 || bus.phi_inc_o !== 32'h2010) begin
            failures++;
            $display("FAIL abort_step1 got idx=%0d phi=%h exp 1 2010",
                     bus.step_idx, bus.phi_inc_o);
        end
        tick();
        bus.stop = 1;
        tick();
        bus.stop = 0;
        checks++;
        if (bus.busy !== 1'b0 || bus.nco_clken !== 1'b0 ||
            bus.done !== 1'b0 || bus.step_idx !== 16'd1 ||
            bus.phi_inc_o !== 32'h2010) begin
            failures++;
            $display("FAIL abort_idle got b=%b ck=%b d=%b idx=%0d phi=%h exp 0 0 0 1 2010",
                     bus.busy, bus.nco_clken, bus.done,
                     bus.step_idx, bus.phi_inc_o);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done got d=%b b=%b exp 0 0",
                     bus.done, bus.busy);
        end
        bus.start = 1;
        tick();
        bus.start = 0;
        checks++;
        if (bus.phi_inc_o !== 32'h2000 || bus.step_idx !== 16'd0 ||
            bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_restart got phi=%h idx=%0d b=%b exp 2000 0 1",
                     bus.phi_inc_o, bus.step_idx, bus.busy);
        end
        bus.stop = 1;
        tick();
        bus.stop = 0;
        bus.nco_out_valid = 0;
    endtask

    task automatic test_degenerate();
        bus.f_start = 32'h55; bus.f_step = 32'h1;
        bus.n_steps = 16'd0; bus.dwell = 16'd0;
        bus.nco_out_valid = 0;
        bus.start = 1;
        tick();
        bus.start = 0;
        bus.nco_out_valid = 1;
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL degen_dwell got d=%b b=%b exp 0 1",
                     bus.done, bus.busy);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.phi_inc_o !== 32'h55 ||
            bus.step_idx !== 16'd0) begin
            failures++;
            $display("FAIL degen_done got d=%b phi=%h idx=%0d exp 1 55 0",
                     bus.done, bus.phi_inc_o, bus.step_idx);
        end
        bus.nco_out_valid = 0;
        tick();
    endtask

    task automatic test_conflict();
        bus.f_start = 32'h99;
        bus.start = 1; bus.stop = 1;
        tick();
        bus.start = 0; bus.stop = 0;
        checks++;
        if (bus.busy !== 1'b0 || bus.nco_clken !== 1'b0 ||
            bus.phi_inc_o !== 32'h55) begin
            failures++;
            $display("FAIL conflict got b=%b ck=%b phi=%h exp 0 0 55",
                     bus.busy, bus.nco_clken, bus.phi_inc_o);
        end
    endtask

    task automatic test_reset_mid();
        bus.f_start = 32'h3000; bus.f_step = 32'h1;
        bus.n_steps = 16'd4; bus.dwell = 16'd5;
        bus.nco_out_valid = 1;
        bus.start = 1;
        tick();
        bus.start = 0;
        tick(); tick();
        reset_n = 0;
        #1;
        checks++;
        if ({bus.phi_inc_o, bus.step_idx, bus.nco_clken,
             bus.busy, bus.done} !== '0) begin
            failures++;
            $display("FAIL reset_mid got phi=%h idx=%0d ck=%b b=%b d=%b exp all 0",
                     bus.phi_inc_o, bus.step_idx, bus.nco_clken,
                     bus.busy, bus.done);
        end
        tick();
        reset_n = 1;
        tick(); tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.phi_inc_o !== 32'h0 ||
            bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_restart got b=%b phi=%h d=%b exp 0 0 0",
                     bus.busy, bus.phi_inc_o, bus.done);
        end
        bus.nco_out_valid = 0;
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_gapped_valid();
        test_wrap();
        test_abort();
        test_degenerate();
        test_conflict();
        test_reset_mid();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
